input_port_kbd_fifo: RTL and testbench
======================================

// Module: input_port_kbd_fifo
// PURPOSE
// - Buffered, parametrised hexadecimal-keyboard input port for SAP-2. It sits between the keyboard encoder and the W bus.
// - Each key strobe captures one code into a FIFO. READY (bit 0 of input port 2) flags unread data.
// - The CPU reads the oldest code onto WBUS and pops it with an acknowledge pulse, so keystrokes typed between CPU reads are no longer lost.
// PARAMETERS
// - WIDTH      8   keyboard code and W-bus width, in bits
// - DEPTH      4   FIFO entries; must be a power of 2, >= 2
// - CNT_W      3   count width, = log2(DEPTH)+1
// PORTS
// - CLK        in   1       system clock; all state changes on posedge CLK
// - nCLR       in   1       synchronous, active-low clear, sampled on posedge CLK
// - Keyboard   in   WIDTH   code from the hex keyboard encoder; valid while key_strobe is high
// - key_strobe in   1       encoder key-valid level, already synchronous to CLK, held >= 1 cycle per key
// - nEi        in   1       active-low bus enable; 0 drives head entry onto WBUS
// - ack        in   1       1-cycle pulse; pops the head entry at posedge CLK
// - clr_ovf    in   1       clears the sticky overflow flag
// - WBUS       out  WIDTH   head entry when nEi=0 and not empty; all-Z otherwise
// - ready      out  1       1 while FIFO non-empty (to port 2 bit 0)
// - full       out  1       1 when count == DEPTH
// - overflow   out  1       sticky; set when a push is attempted while full
// - count      out  CNT_W   entries held, 0..DEPTH
// BEHAVIOUR
// - Interface: one clock CLK; reset nCLR is synchronous and active-low.
// - Reset (nCLR=0 at posedge):
//   - wr_ptr=rd_ptr=0, count=0, overflow=0, edge-detect history=0.
//   - Outputs: ready=0, full=0; WBUS=Z regardless of nEi.
//   - Storage contents are don't-care. nCLR overrides every other input that cycle.
// - Push event:
//   - key_strobe=1 while previous-cycle key_strobe=0 (rising edge).
//   - A held key yields exactly one push.
//   - Keyboard is sampled in that same cycle.
// - Push latency: code written at posedge N; ready=1 and count updated after posedge N (visible in cycle N+1).
// - Pop event: ack=1 at posedge with count>0. rd_ptr increments mod DEPTH and count decrements.
// - Pop on empty: ignored; no pointer change, no flag.
// - Push while full, without a simultaneous pop:
//   - The code is discarded and overflow is set to 1.
//   - Stored data, pointers and count are unchanged.
// - Simultaneous push and pop:
//   - Both occur and count is unchanged. This is legal when full (no overflow).
//   - When empty, only the push takes effect; the pop is ignored.
// - Pointers wrap from DEPTH-1 to 0. count never exceeds DEPTH and never goes below 0.
// - WBUS is combinational from the head entry, nEi and count:
//   - The value read is the entry present before any pop at that edge.
//   - nEi=0 with count=0 drives Z; the bus is never driven with stale data.
// - Overflow flag:
//   - Sticky until clr_ovf=1 or nCLR=0.
//   - If clr_ovf and a new overflow occur in the same cycle, set wins.
// - Derived outputs: ready = (count!=0); full = (count==DEPTH). Both are registered-state derived, with no combinational path from inputs.
// STRUCTURE
// - Shared include sap2_defs.vh holds:
//   - `WBUS_W` (8)
//   - `HIGH_Z` pattern
//   - `ZERO_STATE`
// - Sub-module sap2_sync_fifo (WIDTH, DEPTH):
//   - Inputs: push, pop, din; outputs: dout, count, full, empty.
//   - Implements the push/pop/wrap rules above.
// - The top level keeps the strobe edge detector, overflow flag and tri-state WBUS driver.
// TESTING
// - Reset: nCLR=0 for 2 cycles, nEi=0 -> WBUS=Z, ready=0, count=0, overflow=0.
// - Single key: strobe high 3 cycles with Keyboard=8'hAC, then nEi=0 -> one push only; count=1, ready=1, WBUS=8'hAC.
//   - Then ack pulse -> count=0, ready=0, WBUS=Z.
// - Ordering and wrap-around:
//   - Push 8'h01..8'h04, pop 2, push 8'h05, 8'h06.
//   - Reads yield 03, 04, 05, 06 in order; count returns to 0.
// - Overflow: push 5 keys into DEPTH=4 -> full=1, overflow=1 after 5th; contents 1..4 intact.
//   - clr_ovf pulse -> overflow=0.
// - Simultaneous events:
//   - Full FIFO: push 8'hEE with ack in the same cycle -> count stays 4, no overflow, 8'hEE read last.
//   - Empty FIFO: push+ack together -> count=1.
// - Reset mid-operation: count=3, assert nCLR with push and ack active -> next cycle count=0, ready=0, full=0, overflow=0.

Source files
------------

// File: rtl/input_port_kbd_fifo_pkg.sv
// rtl/input_port_kbd_fifo_pkg.sv - shared widths and sizing helper for the SAP-2 keyboard input port
package input_port_kbd_fifo_pkg;

  localparam int WBUS_W     = 8;
  localparam int FIFO_DEPTH = 4;

  // Count must hold 0..DEPTH inclusive, hence one bit more than the pointer.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/input_port_kbd_fifo_sync_fifo.sv
// rtl/input_port_kbd_fifo_sync_fifo.sv - power-of-2 synchronous FIFO with occupancy count
module input_port_kbd_fifo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             nclr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  // A pop frees the slot in the same edge, so push-while-full is legal only alongside a real pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!nclr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (nclr_i && do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/input_port_kbd_fifo.sv
// rtl/input_port_kbd_fifo.sv - buffered hex-keyboard input port: strobe edge detect, FIFO, overflow flag, W-bus driver
module input_port_kbd_fifo
  import input_port_kbd_fifo_pkg::*;
#(
  parameter int WIDTH = WBUS_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             CLK,
  input  logic             nCLR,
  input  logic [WIDTH-1:0] Keyboard,
  input  logic             key_strobe,
  input  logic             nEi,
  input  logic             ack,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] WBUS,
  output logic             ready,
  output logic             full,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);

  logic             strobe_q, strobe_d;
  logic             ovf_q, ovf_d;
  logic             push;
  logic             fifo_empty;
  logic [WIDTH-1:0] head;

  // A held key produces a single push on its rising edge only.
  assign push     = key_strobe && !strobe_q;
  assign strobe_d = key_strobe;

  input_port_kbd_fifo_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (CLK),
    .nclr_i  (nCLR),
    .push_i  (push),
    .pop_i   (ack),
    .din_i   (Keyboard),
    .dout_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (push && full && !ack) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!nCLR) begin
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready    = !fifo_empty;
  assign overflow = ovf_q;
  // Never drive stale storage: an empty FIFO floats the bus even when enabled.
  assign WBUS     = (!nEi && !fifo_empty) ? head : {WIDTH{1'bz}};

endmodule

// File: tb/tb_input_port_kbd_fifo.sv
// tb/tb_input_port_kbd_fifo.sv - directed self-checking bench for input_port_kbd_fifo
module tb_input_port_kbd_fifo;

  logic       clk = 1'b0;
  logic       nclr;
  logic [7:0] kbd;
  logic       strobe;
  logic       nei;
  logic       ack;
  logic       clr_ovf;
  wire  [7:0] wbus;
  logic       ready;
  logic       full;
  logic       overflow;
  logic [2:0] count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  input_port_kbd_fifo dut (
    .CLK        (clk),
    .nCLR       (nclr),
    .Keyboard   (kbd),
    .key_strobe (strobe),
    .nEi        (nei),
    .ack        (ack),
    .clr_ovf    (clr_ovf),
    .WBUS       (wbus),
    .ready      (ready),
    .full       (full),
    .overflow   (overflow),
    .count      (count)
  );

  // Undriven bus: Z in a 4-state simulator, resolves to 0 in a 2-state one.
  function automatic bit bus_idle(input logic [7:0] v);
    return $isunknown(v) || (v == 8'h00);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_key(input logic [7:0] code);
    kbd = code;
    strobe = 1'b1;
    step();
    strobe = 1'b0;
    step();
  endtask

  task automatic pop_read(output logic [7:0] v);
    nei = 1'b0;
    #1;
    v = wbus;
    ack = 1'b1;
    step();
    ack = 1'b0;
    nei = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] b;
    nclr = 1'b0; kbd = 8'h00; strobe = 1'b0; nei = 1'b0; ack = 1'b0; clr_ovf = 1'b0;
    step(); step();
    b = wbus;
    checks++; if (!bus_idle(b)) begin failures++; $display("FAIL reset_wbus got=%h exp=zz", b); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    nclr = 1'b1; nei = 1'b1;
    step();
  endtask

  task automatic test_single_key();
    logic [7:0] v;
    kbd = 8'hAC; strobe = 1'b1;
    step(); step(); step();
    strobe = 1'b0;
    step();
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", ready); end
    pop_read(v);
    checks++; if (v !== 8'hAC) begin failures++; $display("FAIL single_wbus got=%h exp=ac", v); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", count); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL single_pop_ready got=%b exp=0", ready); end
    nei = 1'b0; #1; v = wbus;
    checks++; if (!bus_idle(v)) begin failures++; $display("FAIL single_empty_wbus got=%h exp=zz", v); end
    ack = 1'b1; step(); ack = 1'b0; nei = 1'b1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL pop_empty_count got=%0d exp=0", count); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'h03; exp_rd[1] = 8'h04; exp_rd[2] = 8'h05; exp_rd[3] = 8'h06;
    for (int i = 1; i <= 4; i++) push_key(8'(i));
    checks++; if (count !== 3'd4 || full !== 1'b1) begin failures++; $display("FAIL wrap_fill got=%0d/%b exp=4/1", count, full); end
    pop_read(v);
    checks++; if (v !== 8'h01) begin failures++; $display("FAIL wrap_pop0 got=%h exp=01", v); end
    pop_read(v);
    checks++; if (v !== 8'h02) begin failures++; $display("FAIL wrap_pop1 got=%h exp=02", v); end
    push_key(8'h05);
    push_key(8'h06);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL wrap_count got=%0d exp=4", count); end
    for (int i = 0; i < 4; i++) begin
      pop_read(v);
      checks++; if (v !== exp_rd[i]) begin failures++; $display("FAIL wrap_read%0d got=%h exp=%h", i, v, exp_rd[i]); end
    end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL wrap_end_count got=%0d exp=0", count); end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    for (int i = 1; i <= 4; i++) push_key(8'(i));
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    push_key(8'h55);
    checks++; if (overflow !== 1'b1 || full !== 1'b1 || count !== 3'd4) begin
      failures++; $display("FAIL ovf_set got=%b/%b/%0d exp=1/1/4", overflow, full, count); end
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    // Clear and fresh overflow in the same cycle: set must win.
    kbd = 8'h66; strobe = 1'b1; clr_ovf = 1'b1; step();
    strobe = 1'b0; clr_ovf = 1'b0; step();
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    for (int i = 1; i <= 4; i++) begin
      pop_read(v);
      checks++; if (v !== 8'(i)) begin failures++; $display("FAIL ovf_content%0d got=%h exp=%h", i, v, 8'(i)); end
    end
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [7:0] v;
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'hA2; exp_rd[1] = 8'hA3; exp_rd[2] = 8'hA4; exp_rd[3] = 8'hEE;
    push_key(8'hA1); push_key(8'hA2); push_key(8'hA3); push_key(8'hA4);
    nei = 1'b0; kbd = 8'hEE; strobe = 1'b1; ack = 1'b1;
    #1; v = wbus;
    checks++; if (v !== 8'hA1) begin failures++; $display("FAIL simul_head got=%h exp=a1", v); end
    step();
    ack = 1'b0; strobe = 1'b0; nei = 1'b1;
    step();
    checks++; if (count !== 3'd4 || overflow !== 1'b0) begin
      failures++; $display("FAIL simul_full got=%0d/%b exp=4/0", count, overflow); end
    for (int i = 0; i < 4; i++) begin
      pop_read(v);
      checks++; if (v !== exp_rd[i]) begin failures++; $display("FAIL simul_read%0d got=%h exp=%h", i, v, exp_rd[i]); end
    end
    kbd = 8'h3C; strobe = 1'b1; ack = 1'b1; step();
    strobe = 1'b0; ack = 1'b0; step();
    checks++; if (count !== 3'd1 || ready !== 1'b1) begin
      failures++; $display("FAIL simul_empty got=%0d/%b exp=1/1", count, ready); end
    pop_read(v);
    checks++; if (v !== 8'h3C) begin failures++; $display("FAIL simul_empty_data got=%h exp=3c", v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    for (int i = 1; i <= 5; i++) push_key(8'(8'h10 + i));
    pop_read(v);
    checks++; if (count !== 3'd3 || overflow !== 1'b1) begin
      failures++; $display("FAIL mid_pre got=%0d/%b exp=3/1", count, overflow); end
    kbd = 8'h77; strobe = 1'b1; ack = 1'b1; nclr = 1'b0;
    step();
    checks++; if (count !== 3'd0 || ready !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL mid_reset got=%0d/%b/%b/%b exp=0/0/0/0", count, ready, full, overflow); end
    nclr = 1'b1; strobe = 1'b0; ack = 1'b0;
    step();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL mid_after got=%0d exp=0", count); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_wrap();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
